i2c_master_byte: RTL

- Byte-level I2C master: the initiator counterpart to the team's I2C slave, and the bench driver used to exercise it.
- Accepts one command per handshake: optional START or repeated START, then 8-bit write or read with ACK, then optional STOP.
- Generates SCL and SDA through open-drain enables and honours slave clock stretching.
- Sits between a controller/test sequencer and the top-level SCL/SDA pads.

---
 rtl/i2c_master_byte.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte.sv
`default_nettype none
// ============================================================================
// i2c_master_byte : byte-level I2C master (START/rSTART, 8-bit write or read
//                   with ACK, optional STOP), open-drain enables, SCL stretching
// Revision        : 1.0
// ============================================================================
module i2c_master_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int SCL_FREQ = 100000,
  parameter int QDIV     = CLK_FREQ / (4 * SCL_FREQ)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_read,
  input  logic       cmd_stop,
  input  logic       cmd_nack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       ack_rcvd,
  output logic       busy,
  output logic       bus_held,
  input  logic       scl_i,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_oe
);

  localparam int            CW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_RSTART = 3'd2,
    S_START  = 3'd3,
    S_BIT    = 3'd4,
    S_ACK    = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t        state;
  logic [1:0]    quarter;
  logic [2:0]    bit_idx;
  logic [CW-1:0] qcnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          op_read;
  logic          op_stop;
  logic          op_nack;
  logic          ack_int;
  logic          stretched;
  logic          qtick;

  // A released SCL that is still low means the slave is stretching.
  assign stretched = !scl_oe && !scl_i;
  assign qtick     = (qcnt == QLAST) && !stretched;

  // Line enables are registered and set when a quarter is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      quarter   <= 2'd0;
      bit_idx   <= 3'd0;
      qcnt      <= '0;
      tx_sr     <= 8'd0;
      rx_sr     <= 8'd0;
      op_read   <= 1'b0;
      op_stop   <= 1'b0;
      op_nack   <= 1'b0;
      ack_int   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= 8'd0;
      ack_rcvd  <= 1'b0;
      bus_held  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_ready) begin
        qcnt    <= '0;
        quarter <= 2'd0;
        bit_idx <= 3'd0;
        if (cmd_valid) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          op_read   <= cmd_read;
          op_stop   <= cmd_stop;
          op_nack   <= cmd_nack;
          tx_sr     <= wr_data;
          if (cmd_start && (state == S_HOLD)) begin
            state  <= S_RSTART;
            sda_oe <= 1'b0;
          end else if (cmd_start) begin
            state  <= S_START;
            sda_oe <= 1'b1;
            scl_oe <= 1'b0;
          end else begin
            state  <= S_BIT;
            scl_oe <= 1'b1;
            sda_oe <= !cmd_read && !wr_data[7];
          end
        end
      end else if (!qtick) begin
        if (!stretched) qcnt <= qcnt + 1'b1;
      end else begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
        case (state)
          S_RSTART: begin
            if (quarter == 2'd0) scl_oe <= 1'b0;
            if (quarter == 2'd3) begin
              state  <= S_START;
              sda_oe <= 1'b1;
            end
          end
          S_START: begin
            if (quarter == 2'd1) scl_oe <= 1'b1;
            if (quarter == 2'd3) begin
              state    <= S_BIT;
              bus_held <= 1'b1;
              sda_oe   <= !op_read && !tx_sr[7];
            end
          end
          S_BIT: begin
            if (quarter == 2'd1) scl_oe <= 1'b0;
            if (quarter == 2'd3) begin
              rx_sr  <= {rx_sr[6:0], sda_i};
              tx_sr  <= {tx_sr[6:0], 1'b0};
              scl_oe <= 1'b1;
              if (bit_idx == 3'd7) begin
                state  <= S_ACK;
                sda_oe <= op_read && !op_nack;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                sda_oe  <= !op_read && !tx_sr[6];
              end
            end
          end
          S_ACK: begin
            if (quarter == 2'd1) scl_oe <= 1'b0;
            if (quarter == 2'd3) begin
              scl_oe  <= 1'b1;
              ack_int <= !sda_i;
              if (op_stop) begin
                state  <= S_STOP;
                sda_oe <= 1'b1;
              end else begin
                state     <= S_HOLD;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                if (op_read) rd_data  <= rx_sr;
                else         ack_rcvd <= !sda_i;
              end
            end
          end
          S_STOP: begin
            if (quarter == 2'd0) scl_oe <= 1'b0;
            if (quarter == 2'd2) sda_oe <= 1'b0;
            if (quarter == 2'd3) begin
              state     <= S_IDLE;
              bus_held  <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              if (op_read) rd_data  <= rx_sr;
              else         ack_rcvd <= ack_int;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
